// File: rtl/tlb_pkg.sv
// Shared definitions for the set-associative TLB: default geometry,
// derived-width helpers and the TLB-top controller state encodings.
package tlb_pkg;

  // Default geometry
  localparam int SADDR = 64;  // virtual address width
  localparam int SPAGE = 12;  // page-offset width
  localparam int NSET  = 8;   // sets per way, power of two
  localparam int SPCID = 12;  // PCID width
  localparam int NWAY  = 4;   // ways instantiated by the TLB top

  // Index width for a set count that is a power of two
  function automatic int set_w(input int nset);
    return (nset > 1) ? $clog2(nset) : 1;
  endfunction

  // Physical page number width
  function automatic int ppn_w(input int saddr, input int spage);
    return saddr - spage;
  endfunction

  // Virtual-page tag width; the set index bits are implied by position
  function automatic int tag_w(input int saddr, input int spage, input int nset);
    return saddr - spage - set_w(nset);
  endfunction

  // TLB-top controller states
  typedef enum logic [2:0] {
    ST_WAITING  = 3'b000,
    ST_REQ      = 3'b001,
    ST_MISS     = 3'b010,
    ST_INSERT   = 3'b100,
    ST_SHUTDOWN = 3'b101
  } tlb_state_e;

endpackage : tlb_pkg

// File: rtl/tlb_way.sv
// One way of the set-associative TLB. Each of NSET entries holds a valid
// bit, a virtual-page tag, a PCID and a physical page number. Lookup is
// purely combinational on the current storage; write, invalidate and
// flush update storage at the rising edge with flush > inv > we.
module tlb_way
  import tlb_pkg::*;
#(
  parameter  int P_SADDR = tlb_pkg::SADDR,
  parameter  int P_SPAGE = tlb_pkg::SPAGE,
  parameter  int P_NSET  = tlb_pkg::NSET,
  parameter  int P_SPCID = tlb_pkg::SPCID,
  localparam int SET_W   = set_w(P_NSET),
  localparam int PPN_W   = ppn_w(P_SADDR, P_SPAGE),
  localparam int TAG_W   = tag_w(P_SADDR, P_SPAGE, P_NSET)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [SET_W-1:0]   set,
  input  logic [TAG_W-1:0]   tag,
  input  logic [P_SPCID-1:0] pcid,
  input  logic               we,
  input  logic [PPN_W-1:0]   wpa,
  input  logic               inv,
  input  logic               flush,
  output logic               hit,
  output logic [PPN_W-1:0]   pa,
  output logic               valid
);

  // Entry storage; flops rather than RAM because every entry must clear
  // asynchronously and all valid bits must drop in a single flush cycle.
  logic               vld_reg  [P_NSET];
  logic [TAG_W-1:0]   tag_reg  [P_NSET];
  logic [P_SPCID-1:0] pcid_reg [P_NSET];
  logic [PPN_W-1:0]   pa_reg   [P_NSET];

  // Per-entry key match; the valid bit gates the compare so a cleared
  // entry (all-zero fields) never matches a zero key.
  logic [P_NSET-1:0]  match_vec;

  genvar gi;
  generate
    for (gi = 0; gi < P_NSET; gi++) begin : g_match
      assign match_vec[gi] = vld_reg[gi] &&
                             (tag_reg[gi] == tag) &&
                             (pcid_reg[gi] == pcid);
    end
  endgenerate

  // Combinational lookup of the addressed entry
  assign hit   = match_vec[set];
  assign valid = vld_reg[set];
  assign pa    = pa_reg[set];

  // Storage update: reset and flush clear everything, inv drops only the
  // valid bit, we fills the addressed entry; lower priorities are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < P_NSET; i++) begin
        vld_reg[i]  <= 1'b0;
        tag_reg[i]  <= '0;
        pcid_reg[i] <= '0;
        pa_reg[i]   <= '0;
      end
    end else if (flush) begin
      for (int i = 0; i < P_NSET; i++) begin
        vld_reg[i]  <= 1'b0;
        tag_reg[i]  <= '0;
        pcid_reg[i] <= '0;
        pa_reg[i]   <= '0;
      end
    end else if (inv) begin
      vld_reg[set] <= 1'b0;
    end else if (we) begin
      vld_reg[set]  <= 1'b1;
      tag_reg[set]  <= tag;
      pcid_reg[set] <= pcid;
      pa_reg[set]   <= wpa;
    end
  end

endmodule : tlb_way

// File: tb/tb_tlb_way.sv
// Directed self-checking bench for tlb_way at default geometry.
module tb_tlb_way;

  localparam int SET_W = 3;
  localparam int TAG_W = 49;
  localparam int PPN_W = 52;
  localparam int PCW   = 12;

  logic             clk;
  logic             rst_n;
  logic [SET_W-1:0] set;
  logic [TAG_W-1:0] tag;
  logic [PCW-1:0]   pcid;
  logic             we;
  logic [PPN_W-1:0] wpa;
  logic             inv;
  logic             flush;
  logic             hit;
  logic [PPN_W-1:0] pa;
  logic             valid;

  int n_assert = 0;
  int n_fail   = 0;

  tlb_way dut (
    .clk   (clk),
    .rst_n (rst_n),
    .set   (set),
    .tag   (tag),
    .pcid  (pcid),
    .we    (we),
    .wpa   (wpa),
    .inv   (inv),
    .flush (flush),
    .hit   (hit),
    .pa    (pa),
    .valid (valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  // Advance past the next rising edge, then let outputs settle
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Put a lookup key on the inputs and let the combinational path settle
  task automatic look(input int s, input logic [TAG_W-1:0] t, input logic [PCW-1:0] p);
    set  = SET_W'(s);
    tag  = t;
    pcid = p;
    #1;
  endtask

  initial begin
    rst_n = 1'b0; set = '0; tag = '0; pcid = '0;
    we = 1'b0; wpa = '0; inv = 1'b0; flush = 1'b0;

    // Reset, release away from an edge, then sweep every set with a zero key
    #22;
    rst_n = 1'b1;
    #2;
    for (int s = 0; s < 8; s++) begin
      look(s, '0, '0);
      check($sformatf("reset_hit_s%0d", s), {63'd0, hit}, 64'd0);
      check($sformatf("reset_valid_s%0d", s), {63'd0, valid}, 64'd0);
      check($sformatf("reset_pa_s%0d", s), {12'd0, pa}, 64'd0);
    end
    $display("txn reset sweep done");

    // Write then hit
    look(3, 49'h1_2345, 12'h07A);
    wpa = 52'hABCDE; we = 1'b1;
    tick();
    we = 1'b0;
    #1;
    check("write_hit", {63'd0, hit}, 64'd1);
    check("write_pa", {12'd0, pa}, 64'h ABCDE);
    look(2, 49'h1_2345, 12'h07A);
    check("other_set_hit", {63'd0, hit}, 64'd0);
    $display("txn write set3 tag=12345 pcid=07a pa=abcde");

    // Key mismatch
    look(3, 49'h1_2345, 12'h07B);
    check("pcid_miss_hit", {63'd0, hit}, 64'd0);
    check("pcid_miss_valid", {63'd0, valid}, 64'd1);
    check("pcid_miss_pa", {12'd0, pa}, 64'hABCDE);
    look(3, 49'h1_2346, 12'h07A);
    check("tag_miss_hit", {63'd0, hit}, 64'd0);
    $display("txn mismatch lookups set3");

    // Invalidate set 3; data fields stay
    look(3, 49'h1_2345, 12'h07A);
    inv = 1'b1;
    tick();
    inv = 1'b0;
    #1;
    check("inv_hit", {63'd0, hit}, 64'd0);
    check("inv_valid", {63'd0, valid}, 64'd0);
    check("inv_pa_kept", {12'd0, pa}, 64'hABCDE);
    $display("txn invalidate set3");

    // inv beats we on set 5
    look(5, 49'h55, 12'h005);
    wpa = 52'h5555; inv = 1'b1; we = 1'b1;
    tick();
    inv = 1'b0; we = 1'b0;
    #1;
    check("inv_we_valid", {63'd0, valid}, 64'd0);
    check("inv_we_hit", {63'd0, hit}, 64'd0);
    check("inv_we_pa", {12'd0, pa}, 64'd0);
    $display("txn inv+we set5");

    // Fill every set with a distinct key
    for (int s = 0; s < 8; s++) begin
      look(s, 49'h100 + 49'(s), 12'h010 + 12'(s));
      wpa = 52'h1000 + 52'(s); we = 1'b1;
      tick();
      we = 1'b0;
    end
    for (int s = 0; s < 8; s++) begin
      look(s, 49'h100 + 49'(s), 12'h010 + 12'(s));
      check($sformatf("fill_hit_s%0d", s), {63'd0, hit}, 64'd1);
      check($sformatf("fill_pa_s%0d", s), {12'd0, pa}, 64'h1000 + 64'(s));
    end
    $display("txn fill sets 0..7");

    // Flush with a concurrent write that must be dropped
    look(2, 49'h777, 12'h777);
    wpa = 52'h777; flush = 1'b1; we = 1'b1;
    tick();
    flush = 1'b0; we = 1'b0;
    #1;
    check("flush_we_dropped_hit", {63'd0, hit}, 64'd0);
    for (int s = 0; s < 8; s++) begin
      look(s, 49'h100 + 49'(s), 12'h010 + 12'(s));
      check($sformatf("flush_valid_s%0d", s), {63'd0, valid}, 64'd0);
      check($sformatf("flush_hit_s%0d", s), {63'd0, hit}, 64'd0);
      check($sformatf("flush_pa_s%0d", s), {12'd0, pa}, 64'd0);
    end
    look(0, '0, '0);
    check("flush_zero_key_hit", {63'd0, hit}, 64'd0);
    $display("txn flush");

    // Read-during-write on set 1: old contents until the edge
    look(1, 49'hA1, 12'h0A1);
    wpa = 52'hAAAA; we = 1'b1;
    tick();
    look(1, 49'hB1, 12'h0B1);
    wpa = 52'hBBBB;
    check("rdw_before_hit", {63'd0, hit}, 64'd0);
    check("rdw_before_pa", {12'd0, pa}, 64'hAAAA);
    tick();
    we = 1'b0;
    #1;
    check("rdw_after_hit", {63'd0, hit}, 64'd1);
    check("rdw_after_pa", {12'd0, pa}, 64'hBBBB);
    $display("txn read-during-write set1");

    // Asynchronous reset between edges
    @(posedge clk);
    #2;
    check("pre_async_valid", {63'd0, valid}, 64'd1);
    rst_n = 1'b0;
    #1;
    check("async_valid", {63'd0, valid}, 64'd0);
    check("async_hit", {63'd0, hit}, 64'd0);
    check("async_pa", {12'd0, pa}, 64'd0);
    #3;
    rst_n = 1'b1;
    $display("txn async reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule : tb_tlb_way

// File: doc/tlb_way.md
# tlb_way

One way of the set-associative TLB: NSET entries, each holding a valid bit, virtual-page tag, PCID and physical page number. The TLB top instantiates NWAY copies and drives all of them with the same set index and lookup key. Each copy reports a per-way hit and its stored physical page number. The top's PLRU logic chooses which way gets the write enable.

## Interface
- `SADDR`, 64, address width in bits.
- `SPAGE`, 12, page-offset width; `PPN_W = SADDR-SPAGE`.
- `NSET`, 8, sets per way (power of two); `SET_W = $clog2(NSET)`.
- `SPCID`, 12, PCID width.
- Derived: `TAG_W = SADDR-SPAGE-SET_W` (49 at defaults).

Ports:
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset; one clock, asynchronous, active-low.
- `set`  in  SET_W  set index for lookup and write.
- `tag`  in  TAG_W  lookup/write tag.
- `pcid`  in  SPCID  lookup/write PCID.
- `we`  in  1  write entry `set`.
- `wpa`  in  PPN_W  physical page number to write.
- `inv`  in  1  invalidate entry `set`.
- `flush`  in  1  invalidate all entries.
- `hit`  out  1  entry `set` is valid and matches both `tag` and `pcid`.
- `pa`  out  PPN_W  stored PPN of entry `set`.
- `valid`  out  1  valid bit of entry `set`.

## Operation
- Storage: `vld[NSET]`, `tag_q[NSET]`, `pcid_q[NSET]`, `pa_q[NSET]`.
- Lookup is combinational from the current storage:
  - `hit = vld[set] & tag_q[set]==tag & pcid_q[set]==pcid`.
  - `pa = pa_q[set]` and `valid = vld[set]`, regardless of hit.
- Write (`we`=1): at posedge, `vld[set]<=1`, `tag_q[set]<=tag`, `pcid_q[set]<=pcid`, `pa_q[set]<=wpa`. Other sets are unchanged.
- Invalidate (`inv`=1): `vld[set]<=0`. Tag, PCID and PPN fields keep their values.
- Flush (`flush`=1): all `vld<=0` in one cycle. Data fields are also cleared to 0.
- Priority when inputs are asserted together: `flush` > `inv` > `we`. A lower-priority request in the same cycle is dropped.
- An entry whose fields are all zero but whose valid bit is 0 must never hit, including for lookup tag 0 / pcid 0.
- No internal FSM. Way selection and PLRU state live in the TLB top.

## Timing
- Reset (asynchronous, `rst_n`=0): all `vld`, tag, PCID and PPN fields clear to 0 immediately. Consequently `hit`=0, `valid`=0 and `pa`=0 for every set.
- Deassertion of `rst_n` is synchronised by the top. The way takes no action on deassertion.
- Lookup latency: 0 cycles (combinational).
- Write, invalidate and flush take effect at the posedge. They are visible to lookups from that edge onward.
- Read-during-write to the same set in the same cycle returns the old contents until the edge; there is no bypass.
- Reset asserted mid-write: reset wins and the write is lost.
- `set` out of range is impossible because NSET is a power of two.

## Structure
- Shared package `tlb_pkg` holds:
  - default widths `SADDR`, `SPAGE`, `NSET`, `SPCID`, `NWAY`;
  - derived `TAG_W`, `PPN_W`, `SET_W` helper functions;
  - the TLB-top state encodings: waiting 3'b000, req 3'b001, miss 3'b010, insert 3'b100, shutdown 3'b101.
- Flat register arrays with one always block for storage. No sub-module.
- The top ORs and priority-encodes the NWAY `hit` outputs and muxes `pa`.

## Test plan
- Reset: hold `rst_n`=0, then release. For every `set` 0..7 with `tag`=0 and `pcid`=0 → `hit`=0, `valid`=0, `pa`=0.
- Write then hit: `we` with `set`=3, `tag`=49'h1_2345, `pcid`=12'h07A, `wpa`=52'hABCDE. From the next cycle a lookup with the same key gives `hit`=1 and `pa`=52'hABCDE. Set 2 still gives `hit`=0.
- Key mismatch: after the previous write, look up set 3 with `pcid`=12'h07B → `hit`=0, `valid`=1, `pa`=52'hABCDE. With `tag`=49'h1_2346 → `hit`=0.
- Invalidate and priority:
  - `inv` on set 3 → `hit`=0 and `valid`=0.
  - Then assert `inv`+`we` together on set 5 → set 5 stays invalid.
- Flush: fill sets 0..7 with distinct keys, pulse `flush` for one cycle → all `valid`=0 and `hit`=0. A `we` asserted alongside `flush` is dropped.
- Read-during-write and async reset:
  - In the write cycle to set 1, `hit` shows the old entry. After the edge it shows the new one.
  - Drop `rst_n` between clock edges → `valid` goes to 0 immediately, without waiting for an edge.
